div_share_scheduler: RTL and testbench

//  Sequences one shared pipelined divider between the pan and tilt angle paths.

---
 rtl/div_share_scheduler.sv | 157 +++++++++++++++
 tb/tb_div_share_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_scheduler.sv
// Shares one pipelined divider between the pan and tilt angle paths: round-robin
// grant, operand ordering so the quotient stays <= 1, and result routing by owner.
module div_share_scheduler #(
    parameter int OPW     = 12,
    parameter int QW      = 12,
    parameter int RW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pan_req,
    input  logic [OPW-1:0] pan_a,
    input  logic [OPW-1:0] pan_b,
    output logic           pan_ack,
    input  logic           tilt_req,
    input  logic [OPW-1:0] tilt_a,
    input  logic [OPW-1:0] tilt_b,
    output logic           tilt_ack,
    output logic           div_start,
    output logic [OPW-1:0] div_dividend,
    output logic [OPW-1:0] div_divisor,
    input  logic           div_ready,
    input  logic [QW-1:0]  div_quotient,
    input  logic [RW-1:0]  div_remainder,
    output logic           res_valid,
    output logic           res_owner,
    output logic [QW-1:0]  res_quotient,
    output logic [RW-1:0]  res_remainder,
    output logic           res_a_greater,
    output logic           div_timeout,
    output logic           busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE,
        S_ZERO
    } state_t;

    state_t          state;
    logic            last_grant;   // 0 = pan, 1 = tilt
    logic            owner;
    logic            a_greater;
    logic [CW-1:0]   wait_cnt;

    logic            grant_valid;
    logic            grant_owner;
    logic [OPW-1:0]  grant_a;
    logic [OPW-1:0]  grant_b;

    // Round-robin: a tie goes to the path that was not served last.
    always_comb begin
        grant_valid = pan_req | tilt_req;
        grant_owner = (pan_req && tilt_req) ? ~last_grant : tilt_req;
        grant_a     = grant_owner ? tilt_a : pan_a;
        grant_b     = grant_owner ? tilt_b : pan_b;
    end

    // NOTE: every output is a flop; pulse outputs default low each cycle and are
    // raised on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            a_greater     <= 1'b0;
            wait_cnt      <= '0;
            pan_ack       <= 1'b0;
            tilt_ack      <= 1'b0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            res_valid     <= 1'b0;
            res_owner     <= 1'b0;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_a_greater <= 1'b0;
            div_timeout   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            pan_ack     <= 1'b0;
            tilt_ack    <= 1'b0;
            div_start   <= 1'b0;
            res_valid   <= 1'b0;
            div_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_owner;
                        last_grant <= grant_owner;
                        pan_ack    <= ~grant_owner;
                        tilt_ack   <= grant_owner;
                        busy       <= 1'b1;
                        if (grant_a == '0 && grant_b == '0) begin
                            state <= S_ZERO;
                        end else begin
                            state        <= S_LOAD;
                            div_start    <= 1'b1;
                            a_greater    <= (grant_a > grant_b);
                            div_dividend <= (grant_a > grant_b) ? grant_b : grant_a;
                            div_divisor  <= (grant_a > grant_b) ? grant_a : grant_b;
                        end
                    end
                end

                S_LOAD: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    // A result in the final WAIT cycle still wins over the abort.
                    if (div_ready) begin
                        res_valid     <= 1'b1;
                        res_owner     <= owner;
                        res_quotient  <= div_quotient;
                        res_remainder <= div_remainder;
                        res_a_greater <= a_greater;
                        state         <= S_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        div_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_ZERO: begin
                    res_valid     <= 1'b1;
                    res_owner     <= owner;
                    res_quotient  <= '0;
                    res_remainder <= '0;
                    res_a_greater <= 1'b0;
                    state         <= S_DONE;
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_scheduler.sv
// Directed bench for div_share_scheduler: single transactions, the zero-operand
// shortcut, timeout abort, round-robin alternation and reset in the middle of a divide.
module tb_div_share_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        pan_req, tilt_req;
    logic [11:0] pan_a, pan_b, tilt_a, tilt_b;
    logic        pan_ack, tilt_ack;
    logic        div_start;
    logic [11:0] div_dividend, div_divisor;
    logic        div_ready;
    logic [11:0] div_quotient;
    logic [7:0]  div_remainder;
    logic        res_valid, res_owner;
    logic [11:0] res_quotient;
    logic [7:0]  res_remainder;
    logic        res_a_greater;
    logic        div_timeout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    div_share_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .pan_req       (pan_req),
        .pan_a         (pan_a),
        .pan_b         (pan_b),
        .pan_ack       (pan_ack),
        .tilt_req      (tilt_req),
        .tilt_a        (tilt_a),
        .tilt_b        (tilt_b),
        .tilt_ack      (tilt_ack),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_ready     (div_ready),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .res_valid     (res_valid),
        .res_owner     (res_owner),
        .res_quotient  (res_quotient),
        .res_remainder (res_remainder),
        .res_a_greater (res_a_greater),
        .div_timeout   (div_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [51:0] all_outputs();
        return {pan_ack, tilt_ack, div_start, div_dividend, div_divisor, res_valid,
                res_owner, res_quotient, res_remainder, res_a_greater, div_timeout, busy};
    endfunction

    // Starts in an IDLE cycle with the request(s) already driven; returns in IDLE.
    task automatic run_txn(input string name, input logic exp_owner,
                           input logic [11:0] exp_dvd, input logic [11:0] exp_dvs,
                           input logic exp_ag, input int delay,
                           input logic [11:0] q, input logic [7:0] r);
        logic [1:0] exp_acks;
        exp_acks = exp_owner ? 2'b01 : 2'b10;
        step();
        total++;
        if ({pan_ack, tilt_ack} !== exp_acks) begin
            bad++;
            $display("FAIL %s acks: got=%b exp=%b", name, {pan_ack, tilt_ack}, exp_acks);
        end
        total++;
        if ({div_start, busy} !== 2'b11) begin
            bad++;
            $display("FAIL %s start/busy: got=%b exp=11", name, {div_start, busy});
        end
        total++;
        if ({div_dividend, div_divisor} !== {exp_dvd, exp_dvs}) begin
            bad++;
            $display("FAIL %s operands: got=%0d/%0d exp=%0d/%0d", name,
                     div_dividend, div_divisor, exp_dvd, exp_dvs);
        end
        step();
        if (exp_owner) tilt_req = 1'b0;
        else           pan_req  = 1'b0;
        total++;
        if ({pan_ack, tilt_ack, div_start, res_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL %s pulses_low: got=%b exp=0000", name,
                     {pan_ack, tilt_ack, div_start, res_valid});
        end
        repeat (delay - 1) step();
        div_ready     = 1'b1;
        div_quotient  = q;
        div_remainder = r;
        step();
        div_ready     = 1'b0;
        div_quotient  = ~q;
        div_remainder = ~r;
        total++;
        if ({res_valid, res_owner} !== {1'b1, exp_owner}) begin
            bad++;
            $display("FAIL %s res_valid/owner: got=%b exp=%b", name,
                     {res_valid, res_owner}, {1'b1, exp_owner});
        end
        total++;
        if ({res_quotient, res_remainder, res_a_greater} !== {q, r, exp_ag}) begin
            bad++;
            $display("FAIL %s result: got q=%h r=%h ag=%b exp q=%h r=%h ag=%b", name,
                     res_quotient, res_remainder, res_a_greater, q, r, exp_ag);
        end
        step();
        total++;
        if ({res_valid, busy, res_quotient, res_remainder} !== {2'b00, q, r}) begin
            bad++;
            $display("FAIL %s after_done: got valid=%b busy=%b q=%h r=%h exp 0 0 %h %h",
                     name, res_valid, busy, res_quotient, res_remainder, q, r);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        pan_req   = 1'b0;
        tilt_req  = 1'b0;
        div_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        total++;
        if (all_outputs() !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got=%h exp=0", all_outputs());
        end
        step();
        total++;
        if (all_outputs() !== '0) begin
            bad++;
            $display("FAIL reset_idle: got=%h exp=0", all_outputs());
        end
    endtask

    task automatic test_tilt_single();
        tilt_a = 12'd50; tilt_b = 12'd200; tilt_req = 1'b1;
        run_txn("tilt_single", 1'b1, 12'd50, 12'd200, 1'b0, 3, 12'h000, 8'h40);
    endtask

    task automatic test_pan_single();
        pan_a = 12'd300; pan_b = 12'd100; pan_req = 1'b1;
        run_txn("pan_single", 1'b0, 12'd100, 12'd300, 1'b1, 5, 12'h000, 8'h55);
    endtask

    task automatic test_zero_operands();
        tilt_a = 12'd0; tilt_b = 12'd0; tilt_req = 1'b1;
        step();
        total++;
        if ({pan_ack, tilt_ack, div_start, busy} !== 4'b0101) begin
            bad++;
            $display("FAIL zero_ack: got=%b exp=0101", {pan_ack, tilt_ack, div_start, busy});
        end
        step();
        tilt_req = 1'b0;
        total++;
        if ({res_valid, res_owner, div_start} !== 3'b110) begin
            bad++;
            $display("FAIL zero_valid: got=%b exp=110", {res_valid, res_owner, div_start});
        end
        total++;
        if ({res_quotient, res_remainder, res_a_greater} !== 21'd0) begin
            bad++;
            $display("FAIL zero_result: got q=%h r=%h ag=%b exp 0 0 0",
                     res_quotient, res_remainder, res_a_greater);
        end
        step();
        total++;
        if ({res_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL zero_idle: got=%b exp=00", {res_valid, busy});
        end
    endtask

    task automatic test_timeout();
        logic seen;
        seen  = 1'b0;
        pan_a = 12'd7; pan_b = 12'd9; pan_req = 1'b1;
        step();
        total++;
        if ({pan_ack, div_start, div_dividend, div_divisor} !== {2'b11, 12'd7, 12'd9}) begin
            bad++;
            $display("FAIL timeout_start: got ack=%b start=%b %0d/%0d exp 1 1 7/9",
                     pan_ack, div_start, div_dividend, div_divisor);
        end
        for (int i = 0; i < 64; i++) begin
            step();
            if (i == 0) pan_req = 1'b0;
            seen = seen | div_timeout | res_valid | ~busy;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got=1 exp=0");
        end
        step();
        total++;
        if ({div_timeout, busy, res_valid} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_pulse: got=%b exp=100", {div_timeout, busy, res_valid});
        end
        step();
        total++;
        if (div_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_width: got=%b exp=0", div_timeout);
        end
        div_ready = 1'b1; div_quotient = 12'hABC; div_remainder = 8'h12;
        step();
        div_ready = 1'b0;
        step();
        total++;
        if ({res_valid, busy, res_quotient, res_remainder} !== {2'b00, 12'h000, 8'h00}) begin
            bad++;
            $display("FAIL stray_ready: got valid=%b busy=%b q=%h r=%h exp 0 0 000 00",
                     res_valid, busy, res_quotient, res_remainder);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        pan_a  = 12'd300; pan_b  = 12'd100; pan_req  = 1'b1;
        tilt_a = 12'd50;  tilt_b = 12'd200; tilt_req = 1'b1;
        run_txn("rr_pan1", 1'b0, 12'd100, 12'd300, 1'b1, 2, 12'h000, 8'h55);
        pan_a = 12'd120; pan_b = 12'd40; pan_req = 1'b1;
        run_txn("rr_tilt1", 1'b1, 12'd50, 12'd200, 1'b0, 1, 12'h000, 8'h40);
        tilt_a = 12'd9; tilt_b = 12'd9; tilt_req = 1'b1;
        run_txn("rr_pan2", 1'b0, 12'd40, 12'd120, 1'b1, 4, 12'h000, 8'h55);
        run_txn("rr_tilt2", 1'b1, 12'd9, 12'd9, 1'b0, 2, 12'h001, 8'h00);
    endtask

    task automatic test_reset_mid_op();
        pan_a  = 12'd300; pan_b  = 12'd100; pan_req  = 1'b1;
        tilt_a = 12'd50;  tilt_b = 12'd200; tilt_req = 1'b1;
        step();
        total++;
        if ({pan_ack, tilt_ack} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_grant: got=%b exp=10", {pan_ack, tilt_ack});
        end
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (all_outputs() !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got=%h exp=0", all_outputs());
        end
        run_txn("midrst_pan", 1'b0, 12'd100, 12'd300, 1'b1, 2, 12'h000, 8'h55);
        run_txn("midrst_tilt", 1'b1, 12'd50, 12'd200, 1'b0, 1, 12'h000, 8'h40);
    endtask

    initial begin
        reset = 1'b1;
        pan_req = 1'b0; tilt_req = 1'b0;
        pan_a = '0; pan_b = '0; tilt_a = '0; tilt_b = '0;
        div_ready = 1'b0; div_quotient = '0; div_remainder = '0;
        test_reset();
        test_tilt_single();
        test_pan_single();
        test_zero_operands();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
